// File: rtl/encoder_4to2_df.sv
// Registered 4-to-2 encoder: index of the asserted input bit, plus "any set"
// and "more than one set" flags, all captured together on one clock edge.
module encoder_4to2_df #(
  parameter int PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [1:0] o,
  output logic       valid,
  output logic       err
);

  localparam bit USE_PRIORITY = (PRIORITY != 0);

  // Each index bit is the OR of the inputs whose index has that bit set.
  function automatic logic [1:0] enc_or(input logic [3:0] x);
    enc_or = {x[2] | x[3], x[1] | x[3]};
  endfunction

  // The highest set bit masks every lower one.
  function automatic logic [1:0] enc_pri(input logic [3:0] x);
    enc_pri = {x[3] | x[2], x[3] | (~x[2] & x[1])};
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [3:0] x);
    multi_hot = |(x & (x - 4'd1));
  endfunction

  logic [1:0] o_p0;
  logic       vld_p0;
  logic       err_p0;
  logic [1:0] o_p1;
  logic       vld_p1;
  logic       err_p1;

  // p0: combinational encode of the current input
  always_comb begin
    o_p0   = USE_PRIORITY ? enc_pri(d) : enc_or(d);
    vld_p0 = |d;
    err_p0 = multi_hot(d);
  end

  // p1: all three results registered on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_p1   <= 2'b00;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      o_p1   <= o_p0;
      vld_p1 <= vld_p0;
      err_p1 <= err_p0;
    end
  end

  assign o     = o_p1;
  assign valid = vld_p1;
  assign err   = err_p1;

endmodule

// File: tb/tb_encoder_4to2_df.sv
// Bench for encoder_4to2_df: both resolution modes run side by side against
// an index-arithmetic reference model through an expected-value queue.
module tb_encoder_4to2_df;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d   = 4'b0000;

  logic [1:0] o0, o1;
  logic       valid0, valid1, err0, err1;

  encoder_4to2_df #(.PRIORITY(0)) dut_or (
    .clk(clk), .rst(rst), .d(d), .o(o0), .valid(valid0), .err(err0)
  );
  encoder_4to2_df #(.PRIORITY(1)) dut_pri (
    .clk(clk), .rst(rst), .d(d), .o(o1), .valid(valid1), .err(err1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic [1:0] o_or;
    logic [1:0] o_pri;
    logic       vld;
    logic       er;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: indices of set bits, combined by OR or by maximum.
  function automatic exp_t model(input logic [3:0] x);
    exp_t e;
    int   or_idx = 0;
    int   max_idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (x[i]) begin
        or_idx  = or_idx | i;
        max_idx = i;
      end
    end
    e.din   = x;
    e.o_or  = 2'(or_idx);
    e.o_pri = 2'(max_idx);
    e.vld   = (x != 4'd0);
    e.er    = ($countones(x) >= 2);
    return e;
  endfunction

  // Each edge out of reset captures the current d.
  always @(posedge clk) begin
    if (!rst && !done) exp_q.push_back(model(d));
  end

  // Monitor: outputs are presented every cycle, checked just after the edge.
  always @(posedge clk) begin
    #1;
    if (!done) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("or.o d=%b", e.din),     o0,     e.o_or);
        check($sformatf("or.valid d=%b", e.din), valid0, e.vld);
        check($sformatf("or.err d=%b", e.din),   err0,   e.er);
        check($sformatf("pri.o d=%b", e.din),    o1,     e.o_pri);
        check($sformatf("pri.valid d=%b", e.din), valid1, e.vld);
        check($sformatf("pri.err d=%b", e.din),  err1,   e.er);
      end else if (rst) begin
        check("rst.o",     {o1, o0},         0);
        check("rst.valid", {valid1, valid0}, 0);
        check("rst.err",   {err1, err0},     0);
      end else begin
        check("scoreboard underflow", 1, 0);
      end
    end
  end

  task automatic drive(input logic [3:0] x);
    @(negedge clk);
    d = x;
  endtask

  initial begin
    logic [3:0] dir[$];
    // reset held with a live input
    d = 4'b1000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // one-hot sweep, zero/one distinction, multi-hot patterns of both modes
    dir = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001,
            4'b0110, 4'b0101, 4'b1111, 4'b0011, 4'b1100, 4'b1010};
    foreach (dir[i]) drive(dir[i]);
    // mid-stream asynchronous reset pulse between edges
    drive(4'b0100);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async.o",     {o1, o0},         0);
    check("async.valid", {valid1, valid0}, 0);
    check("async.err",   {err1, err0},     0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    // randomized traffic, biased towards one-hot and zero inputs
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       drive(4'b0001 << $urandom_range(0, 3));
        1:       drive(4'b0000);
        default: drive(4'($urandom_range(0, 15)));
      endcase
    end
    repeat (2) @(negedge clk);
    done = 1;
    #2;
    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/encoder_4to2_df.md
Name:
encoder_4to2_df

Overview:
- Registered 4-to-2 binary encoder, dataflow style.
- Each clock it samples a 4-bit input `d` and outputs the 2-bit index of the asserted bit on `o`.
- Also flags whether any input bit was set (`valid`) and whether more than one was set (`err`).
- Sits between one-hot request/select sources and binary-indexed logic such as mux selects and address fields.

Parameters:
- PRIORITY, default 0: multi-hot resolution mode.
  - 0: plain OR-encoding, o[0]=d[1]|d[3], o[1]=d[2]|d[3].
  - 1: highest-index set bit wins.

Ports:
- clk    input   1  rising-edge clock
- rst    input   1  asynchronous reset, active-high
- d      input   4  data input, nominally one-hot
- o      output  2  encoded index of d, registered
- valid  output  1  registered; 1 when sampled d != 0
- err    output  1  registered; 1 when sampled d has two or more bits set

Behaviour:
- Reset (rst=1, asynchronous, immediate):
  - o=2'b00, valid=0, err=0.
  - Outputs hold these values while rst=1.
- Release: first capture is on the first rising clk edge with rst=0.
- Latency: 1 cycle. Outputs update on the rising clk edge after d is applied; they are stable between edges.
- No handshake: d is sampled every cycle.
- One-hot d:
  - 0001 -> o=00
  - 0010 -> o=01
  - 0100 -> o=10
  - 1000 -> o=11
  - valid=1, err=0.
- d = 0000: o=00, valid=0, err=0. Downstream must qualify o with valid, because 0000 and 0001 produce the same o.
- Multi-hot d (popcount >= 2): err=1, valid=1.
  - PRIORITY=0: o=OR-encoding, e.g. 0110 -> 11, 0011 -> 01, 1111 -> 11.
  - PRIORITY=1: o=index of highest set bit, e.g. 0110 -> 10, 0011 -> 01, 1111 -> 11.
- err popcount: computed combinationally on d and registered together with o and valid, so all three outputs always refer to the same sample.
- X/Z on d: no defined output is required, but the encoder must not latch state beyond one cycle.
- Reset asserted mid-stream:
  - Outputs clear asynchronously, regardless of clk.
  - The d sample present at the edge where reset deasserts is not captured; capture starts on the next rising edge.

Test Plan:
- Reset: hold rst=1 for 3 cycles with d=1000 -> o=00, valid=0, err=0 throughout; deassert rst -> next edge gives o=11, valid=1.
- One-hot sweep: d=0001,0010,0100,1000, each held 10 ns (clk period 10 ns) -> o=00,01,10,11 appear one cycle after each input, valid=1, err=0.
- Zero input: d=0000 -> o=00, valid=0, err=0; then d=0001 -> o=00, valid=1 (valid is the distinguishing flag).
- Multi-hot, PRIORITY=0: d=0110 -> o=11, err=1; d=0101 -> o=10, err=1; d=1111 -> o=11, err=1.
- Multi-hot, PRIORITY=1: d=0110 -> o=10, err=1; d=0011 -> o=01, err=1; d=1100 -> o=11, err=1.
- Mid-operation reset: d=0100 steady, pulse rst between clock edges -> o=00, valid=0 immediately (asynchronously); after release, o returns to 10 on the next edge.
